// File: rtl/compress_pipe.sv
// Two-stage compress/decompress pipeline for mod-Q coefficients. S1 forms the
// per-lane numerator and fault flags; S2 divides (reciprocal multiply) or shifts.
module compress_pipe #(
    parameter int LANES = 4,
    parameter int Q     = 3329
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [4:0]           d,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*LANES-1:0]  x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*LANES-1:0]  result,
    output logic [LANES-1:0]     err,
    output logic [15:0]          beat_cnt
);

    // Numerators stay below 2^28. With K = NW + clog2(Q) the reciprocal error
    // over that range is below 1/Q, so the multiply-shift quotient is exact.
    localparam int NW = 28;
    localparam int K  = NW + $clog2(Q);
    localparam int MW = NW + 2;
    localparam int PW = NW + MW;
    localparam logic [MW-1:0] RECIP = MW'(((64'd1 << K) + 64'(Q) - 64'd1) / 64'(Q));
    localparam logic [NW-1:0] Q_NW  = NW'(Q);
    localparam logic [NW-1:0] HALF  = NW'(Q / 2);
    localparam logic [16:0]   Q17   = 17'(Q);

    logic                 stall;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_mode_q, s1_mode_d;
    logic [4:0]           s1_d_q, s1_d_d;
    logic [NW-1:0]        s1_num_q [LANES];
    logic [NW-1:0]        s1_num_d [LANES];
    logic [LANES-1:0]     s1_err_q, s1_err_d;
    logic                 out_valid_q, out_valid_d;
    logic [16*LANES-1:0]  result_q, result_d;
    logic [LANES-1:0]     err_q, err_d;
    logic [15:0]          beat_cnt_q, beat_cnt_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = enable && !stall;

    always_comb begin : s1_comb
        logic [15:0] xi;
        logic        d_legal;
        logic        bad;
        // NOTE: every always_comb output gets a default first; a path that skips an assignment would otherwise infer a latch.
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_d_d     = s1_d_q;
        s1_err_d   = s1_err_q;
        s1_num_d   = s1_num_q;
        d_legal    = (d >= 5'd1) && (d <= 5'd11);
        xi         = '0;
        bad        = 1'b0;
        if (!stall) begin
            s1_valid_d = in_valid && in_ready;
            s1_mode_d  = mode;
            s1_d_d     = d;
            for (int i = 0; i < LANES; i++) begin
                xi = x[16*i +: 16];
                if (!mode) bad = !d_legal || ({1'b0, xi} >= Q17);
                else       bad = !d_legal || ((xi >> d) != 16'd0);
                s1_err_d[i] = bad;
                if (bad)        s1_num_d[i] = '0;
                else if (!mode) s1_num_d[i] = (NW'(xi) << d) + HALF;
                else            s1_num_d[i] = NW'(xi) * Q_NW + (NW'(1) << (d - 5'd1));
            end
        end
    end

    always_comb begin : s2_comb
        logic [15:0] mask;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        err_d       = err_q;
        mask        = (16'd1 << s1_d_q) - 16'd1;
        if (!stall) begin
            out_valid_d = s1_valid_q;
            err_d       = s1_err_q;
            for (int i = 0; i < LANES; i++) begin
                if (s1_err_q[i])
                    result_d[16*i +: 16] = 16'd0;
                else if (!s1_mode_q)
                    result_d[16*i +: 16] = 16'((PW'(s1_num_q[i]) * PW'(RECIP)) >> K) & mask;
                else
                    result_d[16*i +: 16] = 16'(s1_num_q[i] >> s1_d_q);
            end
        end
        beat_cnt_d = beat_cnt_q;
        if (out_valid_q && out_ready) beat_cnt_d = beat_cnt_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_d_q      <= 5'd0;
            s1_err_q    <= '0;
            // NOTE: the lane numerator array is small and reset for deterministic bubbles; large RAMs would not be.
            for (int i = 0; i < LANES; i++) s1_num_q[i] <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= '0;
            beat_cnt_q  <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_d_q      <= s1_d_d;
            s1_err_q    <= s1_err_d;
            s1_num_q    <= s1_num_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_compress_pipe.sv
// Scoreboard bench for compress_pipe: an arithmetic model predicts each accepted
// beat, the monitor compares in delivery order; scenario tasks add direct checks.
module tb_compress_pipe;

    localparam int LANES = 4;
    localparam int Q     = 3329;

    logic                 clk = 1'b0;
    logic                 rst_n, enable, mode, in_valid, in_ready;
    logic                 out_valid, out_ready;
    logic [4:0]           d;
    logic [16*LANES-1:0]  x, result;
    logic [LANES-1:0]     err;
    logic [15:0]          beat_cnt;

    typedef struct packed {
        logic [16*LANES-1:0] res;
        logic [LANES-1:0]    err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    compress_pipe #(.LANES(LANES), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .d(d),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic m, input logic [4:0] dd,
                                   input logic [16*LANES-1:0] xx);
        exp_t e;
        e.res = '0;
        e.err = '0;
        for (int i = 0; i < LANES; i++) begin
            longint xi  = longint'(xx[16*i +: 16]);
            longint r   = 0;
            bit     bad = 0;
            if (dd < 1 || dd > 11) bad = 1;
            else if (m == 1'b0)    bad = (xi >= Q);
            else                   bad = (xi >= (longint'(1) << dd));
            if (!bad) begin
                if (m == 1'b0) r = (((xi << dd) + Q / 2) / Q) % (longint'(1) << dd);
                else           r = (xi * Q + (longint'(1) << (dd - 1))) >> dd;
            end
            e.err[i]          = bad;
            e.res[16*i +: 16] = 16'(r);
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat result=%h err=%b (scoreboard empty)", result, err);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || err !== e.err) begin
                    failures++;
                    $display("FAIL scoreboard_beat got result=%h err=%b expected result=%h err=%b",
                             result, err, e.res, e.err);
                end
            end
        end
        if (rst_n && in_valid && in_ready) sb.push_back(model(mode, d, x));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [4:0] dd, input logic [16*LANES-1:0] xx);
        int g = 0;
        mode = m; d = dd; x = xx; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mode = 1'b0; d = 5'd1; x = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (result !== '0 || err !== '0) begin
            failures++; $display("FAIL reset_result got=%h/%b exp=0/0", result, err);
        end
        checks++;
        if (beat_cnt !== 16'd0) begin failures++; $display("FAIL reset_beat_cnt got=%h exp=0", beat_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_compress_d1();
        send(1'b0, 5'd1, {16'd0, 16'd2497, 16'd833, 16'd832});
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== {16'd0, 16'd0, 16'd1, 16'd0} || err !== 4'b0000) begin
            failures++;
            $display("FAIL compress_d1 got v=%b r=%h e=%b exp v=1 r=0000000000010000 e=0000",
                     out_valid, result, err);
        end
        drain();
    endtask

    task automatic test_compress_edges();
        send(1'b0, 5'd10, {16'd0, 16'd0, 16'd1665, 16'd3328});
        @(negedge clk); @(negedge clk);
        checks++;
        if (result !== {16'd0, 16'd0, 16'd512, 16'd0} || err !== 4'b0000) begin
            failures++; $display("FAIL compress_d10 got r=%h e=%b exp r=0000000002000000 e=0000", result, err);
        end
        send(1'b0, 5'd11, {16'd3329, 16'd0, 16'd3328, 16'd1665});
        @(negedge clk); @(negedge clk);
        checks++;
        if (result !== {16'd0, 16'd0, 16'd2047, 16'd1024} || err !== 4'b1000) begin
            failures++; $display("FAIL compress_d11 got r=%h e=%b exp r=0000000007ff0400 e=1000", result, err);
        end
        drain();
    endtask

    task automatic test_decompress();
        send(1'b1, 5'd10, {16'd0, 16'd0, 16'd0, 16'd1});
        @(negedge clk); @(negedge clk);
        checks++;
        if (result !== {16'd0, 16'd0, 16'd0, 16'd3} || err !== 4'b0000) begin
            failures++; $display("FAIL decompress_d10 got r=%h e=%b exp r=0000000000000003 e=0000", result, err);
        end
        send(1'b1, 5'd4, {16'd16, 16'd15, 16'd0, 16'd7});
        @(negedge clk); @(negedge clk);
        checks++;
        if (result !== {16'd0, 16'd3121, 16'd0, 16'd1456} || err !== 4'b1000) begin
            failures++; $display("FAIL decompress_d4 got r=%h e=%b exp r=00000c31000005b0 e=1000", result, err);
        end
        drain();
    endtask

    task automatic test_illegal_d();
        send(1'b0, 5'd0, {16'd4, 16'd3, 16'd2, 16'd1});
        @(negedge clk); @(negedge clk);
        checks++;
        if (result !== '0 || err !== 4'b1111) begin
            failures++; $display("FAIL illegal_d0 got r=%h e=%b exp r=0 e=1111", result, err);
        end
        send(1'b1, 5'd12, {16'd3000, 16'd100, 16'd5, 16'd0});
        @(negedge clk); @(negedge clk);
        checks++;
        if (result !== '0 || err !== 4'b1111) begin
            failures++; $display("FAIL illegal_d12 got r=%h e=%b exp r=0 e=1111", result, err);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int k = 0, stall_seen = 0, bad_ready = 0, bad_hold = 0;
        logic [16*LANES-1:0] held = '0;
        logic [15:0] start = beat_cnt;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (k < 6);
            mode      = k[0];
            d         = 5'(k + 2);
            x         = {16'(k * 7), 16'(k * 3), 16'(k + 100), 16'(k)};
            @(negedge clk);
            if (out_valid && !out_ready) begin
                stall_seen++;
                if (in_ready) bad_ready++;
                if (stall_seen == 1) held = result;
                else if (result !== held) bad_hold++;
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        checks++;
        if (stall_seen != 3) begin failures++; $display("FAIL stall_cycles got=%0d exp=3", stall_seen); end
        checks++;
        if (bad_ready != 0) begin failures++; $display("FAIL stall_in_ready got=%0d cycles high exp=0", bad_ready); end
        checks++;
        if (bad_hold != 0) begin failures++; $display("FAIL stall_hold got=%0d changes exp=0", bad_hold); end
        checks++;
        if (k != 6) begin failures++; $display("FAIL b2b_accepts got=%0d exp=6", k); end
        checks++;
        if (beat_cnt !== 16'(start + 16'd6)) begin
            failures++; $display("FAIL b2b_beat_cnt got=%h exp=%h", beat_cnt, 16'(start + 16'd6));
        end
    endtask

    task automatic test_enable();
        int ready_hi = 0;
        logic [15:0] start = beat_cnt;
        send(1'b0, 5'd8, {16'd100, 16'd200, 16'd300, 16'd3328});
        enable = 1'b0; in_valid = 1'b1; mode = 1'b1; d = 5'd6; x = {16'd63, 16'd1, 16'd2, 16'd64};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_ready) ready_hi++;
            tick();
        end
        checks++;
        if (ready_hi != 0) begin failures++; $display("FAIL enable_low_in_ready got=%0d exp=0", ready_hi); end
        checks++;
        if (beat_cnt !== 16'(start + 16'd1)) begin
            failures++; $display("FAIL enable_inflight got=%h exp=%h", beat_cnt, 16'(start + 16'd1));
        end
        enable = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_midflight();
        int ov_seen = 0;
        mode = 1'b0; d = 5'd5; x = {16'd1, 16'd2, 16'd3, 16'd4}; in_valid = 1'b1;
        tick();
        x = {16'd10, 16'd20, 16'd30, 16'd40};
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || beat_cnt !== 16'd0) begin
            failures++; $display("FAIL midflight_reset got v=%b cnt=%h exp v=0 cnt=0", out_valid, beat_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        checks++;
        if (ov_seen != 0) begin failures++; $display("FAIL post_reset_delivery got=%0d exp=0", ov_seen); end
        tick();
    endtask

    task automatic test_wrap();
        logic [16*LANES-1:0] xv;
        out_ready = 1'b1; enable = 1'b1; in_valid = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            for (int i = 0; i < LANES; i++) xv[16*i +: 16] = 16'($urandom_range(0, 4000));
            mode = 1'($urandom);
            d    = 5'($urandom_range(0, 12));
            x    = xv;
            tick();
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (beat_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffff", beat_cnt); end
        send(1'b1, 5'd11, {16'd2047, 16'd2048, 16'd1, 16'd0});
        drain();
        checks++;
        if (beat_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_post got=%h exp=0000", beat_cnt); end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_compress_d1();
        test_compress_edges();
        test_decompress();
        test_illegal_d();
        test_back_to_back();
        test_enable();
        test_reset_midflight();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
